// File: rtl/writeback_arbiter.sv
// Round-robin commit of five execution-unit results onto two registered register-file write ports.
// Results committed one cycle after ack; backpressure only by withholding combinational ack, no buffering.
module writeback_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu1_valid,
    input  logic [5:0]  alu1_rd,
    input  logic [63:0] alu1_data,
    input  logic        alu2_valid,
    input  logic [5:0]  alu2_rd,
    input  logic [63:0] alu2_data,
    input  logic        advint_valid,
    input  logic [5:0]  advint_rd,
    input  logic [63:0] advint_data,
    input  logic [5:0]  advint_rd2,
    input  logic [63:0] advint_data2,
    input  logic        memunit_valid,
    input  logic [5:0]  memunit_rd,
    input  logic [63:0] memunit_data,
    input  logic        branch_valid,
    input  logic [5:0]  branch_rd,
    input  logic [63:0] branch_data,
    output logic        alu1_ack,
    output logic        alu2_ack,
    output logic        advint_ack,
    output logic        memunit_ack,
    output logic        branch_ack,
    output logic        wr1_en,
    output logic [5:0]  wr1_rn,
    output logic [63:0] wr1_data,
    output logic        wr2_en,
    output logic [5:0]  wr2_rn,
    output logic [63:0] wr2_data,
    output logic [5:0]  reg1_finished,
    output logic [5:0]  reg2_finished
);

    typedef struct packed {
        logic        en;
        logic [5:0]  rn;
        logic [63:0] data;
    } wport_t;

    localparam logic [2:0] SRC_ADVINT = 3'd2;
    localparam logic [2:0] SRC_LAST   = 3'd4;

    logic [4:0]  src_vld;
    logic [5:0]  src_rd  [5];
    logic [63:0] src_dat [5];

    logic [2:0]  rr_q, rr_d;
    wport_t      p1_q, p1_d;
    wport_t      p2_q, p2_d;
    logic [4:0]  grant;

    // Source index order matches the round-robin pointer encoding.
    assign src_vld    = {branch_valid, memunit_valid, advint_valid, alu2_valid, alu1_valid};
    assign src_rd[0]  = alu1_rd;
    assign src_rd[1]  = alu2_rd;
    assign src_rd[2]  = advint_rd;
    assign src_rd[3]  = memunit_rd;
    assign src_rd[4]  = branch_rd;
    assign src_dat[0] = alu1_data;
    assign src_dat[1] = alu2_data;
    assign src_dat[2] = advint_data;
    assign src_dat[3] = memunit_data;
    assign src_dat[4] = branch_data;

    always_comb begin
        logic [3:0] idx;
        logic [2:0] idx3;
        logic       prim_nz;
        logic       sec_nz;
        logic [1:0] cost;
        logic [1:0] free;
        logic       any_nz;
        logic [2:0] last_idx;

        grant    = '0;
        p1_d     = '0;
        p2_d     = '0;
        free     = 2'd2;
        any_nz   = 1'b0;
        last_idx = rr_q;
        idx      = '0;
        idx3     = '0;
        prim_nz  = 1'b0;
        sec_nz   = 1'b0;
        cost     = '0;

        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, rr_q} + 4'(k);
            if (idx >= 4'd5) begin
                idx = idx - 4'd5;
            end
            idx3    = idx[2:0];
            prim_nz = (src_rd[idx3] != 6'd0);
            sec_nz  = (idx3 == SRC_ADVINT) && (advint_rd2 != 6'd0);
            cost    = {1'b0, prim_nz} + {1'b0, sec_nz};

            // A source that does not fit is skipped whole; later sources may still fit.
            if (src_vld[idx3] && (cost <= free)) begin
                grant[idx3] = 1'b1;
                if (prim_nz) begin
                    if (free == 2'd2) begin
                        p1_d = '{en: 1'b1, rn: src_rd[idx3], data: src_dat[idx3]};
                    end else begin
                        p2_d = '{en: 1'b1, rn: src_rd[idx3], data: src_dat[idx3]};
                    end
                    free = free - 2'd1;
                end
                if (sec_nz) begin
                    if (free == 2'd2) begin
                        p1_d = '{en: 1'b1, rn: advint_rd2, data: advint_data2};
                    end else begin
                        p2_d = '{en: 1'b1, rn: advint_rd2, data: advint_data2};
                    end
                    free = free - 2'd1;
                end
                if (cost != 2'd0) begin
                    any_nz   = 1'b1;
                    last_idx = idx3;
                end
            end
        end

        rr_d = rr_q;
        if (any_nz) begin
            rr_d = (last_idx == SRC_LAST) ? 3'd0 : last_idx + 3'd1;
        end
    end

    assign alu1_ack    = grant[0] & ~rst;
    assign alu2_ack    = grant[1] & ~rst;
    assign advint_ack  = grant[2] & ~rst;
    assign memunit_ack = grant[3] & ~rst;
    assign branch_ack  = grant[4] & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 3'd0;
            p1_q <= '0;
            p2_q <= '0;
        end else begin
            rr_q <= rr_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
        end
    end

    assign wr1_en        = p1_q.en;
    assign wr1_rn        = p1_q.rn;
    assign wr1_data      = p1_q.data;
    assign wr2_en        = p2_q.en;
    assign wr2_rn        = p2_q.rn;
    assign wr2_data      = p2_q.data;
    assign reg1_finished = p1_q.en ? p1_q.rn : 6'd0;
    assign reg2_finished = p2_q.en ? p2_q.rn : 6'd0;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter with hand-computed grants and port contents.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu1_valid, alu2_valid, advint_valid, memunit_valid, branch_valid;
    logic [5:0]  alu1_rd, alu2_rd, advint_rd, advint_rd2, memunit_rd, branch_rd;
    logic [63:0] alu1_data, alu2_data, advint_data, advint_data2, memunit_data, branch_data;
    logic        alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack;
    logic        wr1_en, wr2_en;
    logic [5:0]  wr1_rn, wr2_rn, reg1_finished, reg2_finished;
    logic [63:0] wr1_data, wr2_data;

    int n_checks = 0;
    int n_errors = 0;
    int commits9 = 0;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk(clk), .rst(rst),
        .alu1_valid(alu1_valid), .alu1_rd(alu1_rd), .alu1_data(alu1_data),
        .alu2_valid(alu2_valid), .alu2_rd(alu2_rd), .alu2_data(alu2_data),
        .advint_valid(advint_valid), .advint_rd(advint_rd), .advint_data(advint_data),
        .advint_rd2(advint_rd2), .advint_data2(advint_data2),
        .memunit_valid(memunit_valid), .memunit_rd(memunit_rd), .memunit_data(memunit_data),
        .branch_valid(branch_valid), .branch_rd(branch_rd), .branch_data(branch_data),
        .alu1_ack(alu1_ack), .alu2_ack(alu2_ack), .advint_ack(advint_ack),
        .memunit_ack(memunit_ack), .branch_ack(branch_ack),
        .wr1_en(wr1_en), .wr1_rn(wr1_rn), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_rn(wr2_rn), .wr2_data(wr2_data),
        .reg1_finished(reg1_finished), .reg2_finished(reg2_finished)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ack vector order: {alu1, alu2, advint, memunit, branch}
    task automatic chk_acks(input string tag, input logic [4:0] exp);
        #1;
        check(tag, {59'b0, alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack}, {59'b0, exp});
    endtask

    task automatic chk_ports(input string tag,
                             input logic e1, input logic [5:0] r1, input logic [63:0] d1,
                             input logic e2, input logic [5:0] r2, input logic [63:0] d2);
        check({tag, ".wr1"}, {wr1_en, wr1_rn, wr1_data}, {e1, r1, d1});
        check({tag, ".wr2"}, {wr2_en, wr2_rn, wr2_data}, {e2, r2, d2});
        check({tag, ".fin1"}, {58'b0, reg1_finished}, {58'b0, (e1 ? r1 : 6'd0)});
        check({tag, ".fin2"}, {58'b0, reg2_finished}, {58'b0, (e2 ? r2 : 6'd0)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if ((wr1_en && wr1_rn == 6'd9) || (wr2_en && wr2_rn == 6'd9)) commits9++;
    endtask

    task automatic clr();
        {alu1_valid, alu2_valid, advint_valid, memunit_valid, branch_valid} = '0;
        {alu1_rd, alu2_rd, advint_rd, advint_rd2, memunit_rd, branch_rd} = '0;
        {alu1_data, alu2_data, advint_data, advint_data2, memunit_data, branch_data} = '0;
    endtask

    // The scheduler never lets both ports target the same register.
    always @(negedge clk) begin
        if (!rst && wr1_en && wr2_en && wr1_rn != 6'd0)
            check("dup_rn", {63'b0, wr1_rn == wr2_rn}, 64'd0);
    end

    initial begin
        rst = 1'b1;
        clr();
        alu1_valid = 1; alu1_rd = 1; alu2_valid = 1; alu2_rd = 2;
        advint_valid = 1; advint_rd = 3; memunit_valid = 1; memunit_rd = 4;
        branch_valid = 1; branch_rd = 5;
        chk_acks("rst_acks", 5'b00000);
        step();
        step();
        chk_ports("rst_ports", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        clr();
        step();
        chk_ports("post_rst", 0, 0, 0, 0, 0, 0);

        // Single ALU write, rr 0 -> 1
        alu1_valid = 1; alu1_rd = 5; alu1_data = 64'hDEAD;
        chk_acks("single_ack", 5'b10000);
        step();
        clr();
        chk_ports("single", 1, 5, 64'hDEAD, 0, 0, 0);

        // rr=1: advint needs 2 slots, only 1 left after alu2, so skipped; memunit fits
        alu2_valid = 1; alu2_rd = 12; alu2_data = 64'h12;
        advint_valid = 1; advint_rd = 10; advint_data = 64'h1; advint_rd2 = 11; advint_data2 = 64'h2;
        memunit_valid = 1; memunit_rd = 13; memunit_data = 64'h13;
        chk_acks("skip_ack", 5'b01010);
        step();
        alu2_valid = 0; memunit_valid = 0;
        chk_ports("skip", 1, 12, 64'h12, 1, 13, 64'h13);
        // rr=4: advint alone with two destinations
        chk_acks("dual_ack", 5'b00100);
        step();
        clr();
        chk_ports("dual", 1, 10, 64'h1, 1, 11, 64'h2);

        // rr=3: branch alone moves rr back to 0
        branch_valid = 1; branch_rd = 20; branch_data = 64'h20;
        chk_acks("br_ack", 5'b00001);
        step();
        clr();
        chk_ports("br", 1, 20, 64'h20, 0, 0, 0);

        // Contention from rr=0: {alu1,alu2} -> {advint x2} -> {memunit,branch}
        alu1_valid = 1; alu1_rd = 1; alu1_data = 64'h101;
        alu2_valid = 1; alu2_rd = 2; alu2_data = 64'h102;
        advint_valid = 1; advint_rd = 3; advint_data = 64'h103; advint_rd2 = 6; advint_data2 = 64'h106;
        memunit_valid = 1; memunit_rd = 4; memunit_data = 64'h104;
        branch_valid = 1; branch_rd = 5; branch_data = 64'h105;
        chk_acks("cont0_ack", 5'b11000);
        step();
        alu1_valid = 0; alu2_valid = 0;
        chk_ports("cont0", 1, 1, 64'h101, 1, 2, 64'h102);
        chk_acks("cont1_ack", 5'b00100);
        step();
        advint_valid = 0;
        chk_ports("cont1", 1, 3, 64'h103, 1, 6, 64'h106);
        chk_acks("cont2_ack", 5'b00011);
        step();
        clr();
        chk_ports("cont2", 1, 4, 64'h104, 1, 5, 64'h105);

        // Held branch while others keep presenting results, rr=0
        commits9 = 0;
        alu1_valid = 1; alu1_rd = 21; alu1_data = 64'hA1;
        alu2_valid = 1; alu2_rd = 22; alu2_data = 64'hA2;
        advint_valid = 1; advint_rd = 23; advint_data = 64'hA3; advint_rd2 = 24; advint_data2 = 64'hA4;
        memunit_valid = 1; memunit_rd = 25; memunit_data = 64'hA5;
        branch_valid = 1; branch_rd = 9; branch_data = 64'h99;
        chk_acks("hold0_ack", 5'b11000);
        step();
        chk_ports("hold0", 1, 21, 64'hA1, 1, 22, 64'hA2);
        chk_acks("hold1_ack", 5'b00100);
        step();
        chk_ports("hold1", 1, 23, 64'hA3, 1, 24, 64'hA4);
        chk_acks("hold2_ack", 5'b00011);
        step();
        branch_valid = 0;
        chk_ports("hold2", 1, 25, 64'hA5, 1, 9, 64'h99);
        chk_acks("hold3_ack", 5'b11000);
        step();
        clr();
        chk_ports("hold3", 1, 21, 64'hA1, 1, 22, 64'hA2);
        check("br_once", 64'(commits9), 64'd1);

        // Zero-destination store rides along with two ALU writes (rr=2)
        alu1_valid = 1; alu1_rd = 7; alu1_data = 64'h77;
        alu2_valid = 1; alu2_rd = 8; alu2_data = 64'h88;
        memunit_valid = 1; memunit_rd = 0; memunit_data = 64'hBAD;
        chk_acks("zero_ack", 5'b11010);
        step();
        clr();
        chk_ports("zero", 1, 7, 64'h77, 1, 8, 64'h88);

        // Non-linking branch alone: acked, no port activity
        branch_valid = 1; branch_rd = 0; branch_data = 64'h55;
        chk_acks("nolink_ack", 5'b00001);
        step();
        clr();
        chk_ports("nolink", 0, 0, 0, 0, 0, 0);

        // Reset mid-operation suppresses ack and discards the pending result
        alu1_valid = 1; alu1_rd = 15; alu1_data = 64'hF;
        chk_acks("pre_mid_ack", 5'b10000);
        rst = 1'b1;
        chk_acks("mid_rst_ack", 5'b00000);
        step();
        chk_ports("mid_rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        clr();
        step();
        chk_ports("after_mid", 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
